// File: rtl/prewish_blinky.sv
// prewish_blinky: student end of the mentor strobe/data link.
// A rising edge on STB_I latches an 8-bit blink mask, which is then played
// MSB first on o_led, each bit held for 2**PRESCALE_BITS clocks, looping
// until a new mask arrives or reset is asserted.
//
// state | meaning
// IDLE  | no mask loaded, LED off, not busy
// RUN   | mask loaded and playing, busy
module prewish_blinky #(
    parameter int PRESCALE_BITS = 22
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       STB_I,
    input  logic [7:0] DAT_I,
    output logic       ACK_O,
    output logic       o_led,
    output logic       o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01
    } state_t;

    localparam logic [PRESCALE_BITS-1:0] PRESCALE_ONE = {{(PRESCALE_BITS-1){1'b0}}, 1'b1};

    // Power-up values match the reset values so the block works without reset.
    state_t                   r_state     = IDLE;
    logic [7:0]               r_mask      = 8'h00;
    logic [2:0]               r_bit_idx   = 3'd7;
    logic [PRESCALE_BITS-1:0] r_prescaler = '0;
    logic                     r_stb_prev  = 1'b0;
    logic                     r_ack       = 1'b0;

    state_t                   w_state_nxt;
    logic [7:0]               w_mask_nxt;
    logic [2:0]               w_bit_idx_nxt;
    logic [PRESCALE_BITS-1:0] w_prescaler_nxt;
    logic                     w_ack_nxt;
    logic                     w_accept;

    assign w_accept = STB_I & ~r_stb_prev;

    // Next-state logic: a qualified strobe (re)loads from any legal state;
    // otherwise RUN advances the prescaler and steps the bit index on wrap.
    always_comb begin
        w_state_nxt     = r_state;
        w_mask_nxt      = r_mask;
        w_bit_idx_nxt   = r_bit_idx;
        w_prescaler_nxt = r_prescaler;
        w_ack_nxt       = 1'b0;
        case (r_state)
            IDLE, RUN: begin
                if (w_accept) begin
                    w_state_nxt     = RUN;
                    w_mask_nxt      = DAT_I;
                    w_bit_idx_nxt   = 3'd7;
                    w_prescaler_nxt = '0;
                    w_ack_nxt       = 1'b1;
                end else if (r_state == RUN) begin
                    w_prescaler_nxt = r_prescaler + PRESCALE_ONE;
                    if (r_prescaler == {PRESCALE_BITS{1'b1}}) begin
                        w_bit_idx_nxt = r_bit_idx - 3'd1;
                    end
                end
            end
            default: begin
                // Illegal encodings recover to IDLE without acknowledging.
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; reset wins over a same-cycle strobe.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_state     <= IDLE;
            r_mask      <= 8'h00;
            r_bit_idx   <= 3'd7;
            r_prescaler <= '0;
            r_stb_prev  <= 1'b0;
            r_ack       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mask      <= w_mask_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_prescaler <= w_prescaler_nxt;
            r_stb_prev  <= STB_I;
            r_ack       <= w_ack_nxt;
        end
    end

    // Outputs are decoded only from registers: no input-to-output path.
    assign ACK_O  = r_ack;
    assign o_busy = (r_state == RUN);
    assign o_led  = (r_state == RUN) & r_mask[r_bit_idx];

endmodule

// File: tb/tb_prewish_blinky.sv
// Testbench for prewish_blinky with PRESCALE_BITS=2 (4 clocks per mask bit).
// The reference model tracks time since the last accepted mask and derives
// the LED from it arithmetically.
module tb_prewish_blinky;

    localparam int PB  = 2;
    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       RST_I = 1'b0;
    logic       STB_I = 1'b0;
    logic [7:0] DAT_I = 8'h00;
    logic       ACK_O;
    logic       o_led;
    logic       o_busy;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic       m_busy = 1'b0;
    logic [7:0] m_mask = 8'h00;
    int         m_k    = 0;
    logic       m_prev = 1'b0;
    logic       m_ack  = 1'b0;
    logic       m_led  = 1'b0;

    prewish_blinky #(.PRESCALE_BITS(PB)) dut (
        .CLK_I (clk),
        .RST_I (RST_I),
        .STB_I (STB_I),
        .DAT_I (DAT_I),
        .ACK_O (ACK_O),
        .o_led (o_led),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // Drive one clock of inputs, advance the model, settle after the edge.
    task automatic tick(input logic stb, input logic [7:0] dat, input logic rst);
        logic acc;
        STB_I = stb;
        DAT_I = dat;
        RST_I = rst;
        @(posedge clk);
        if (rst) begin
            m_busy = 1'b0;
            m_mask = 8'h00;
            m_k    = 0;
            m_prev = 1'b0;
            m_ack  = 1'b0;
        end else begin
            acc    = stb && !m_prev;
            m_prev = stb;
            m_ack  = acc;
            if (acc) begin
                m_busy = 1'b1;
                m_mask = dat;
                m_k    = 0;
            end else if (m_busy) begin
                m_k = m_k + 1;
            end
        end
        m_led = m_busy ? m_mask[7 - ((m_k / CPB) % 8)] : 1'b0;
        #1;
    endtask

    task automatic test_reset();
        total++;
        if (ACK_O !== 1'b0 || o_led !== 1'b0 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL powerup ack=%b led=%b busy=%b required 0 0 0", ACK_O, o_led, o_busy);
        end
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 8'($urandom), 1'b0);
            total++;
            if (ACK_O !== 1'b0 || o_led !== 1'b0 || o_busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d ack=%b led=%b busy=%b required 0 0 0", i, ACK_O, o_led, o_busy);
            end
        end
    endtask

    task automatic test_a5();
        int n_ack = 0;
        logic [7:0] pat = 8'hA5;
        tick(1'b1, 8'hA5, 1'b0);
        n_ack += int'(ACK_O);
        for (int k = 0; k < 70; k++) begin
            if (k > 0) begin
                tick(1'b0, 8'($urandom), 1'b0);
                n_ack += int'(ACK_O);
            end
            total++;
            if (o_led !== pat[7 - ((k / 4) % 8)] || o_busy !== 1'b1 || ACK_O !== m_ack) begin
                bad++;
                $display("FAIL a5 k=%0d led=%b/%b busy=%b/1 ack=%b/%b", k, o_led, pat[7 - ((k / 4) % 8)], o_busy, ACK_O, m_ack);
            end
        end
        total++;
        if (n_ack != 1) begin
            bad++;
            $display("FAIL a5_ack_count got=%0d required=1", n_ack);
        end
    endtask

    task automatic test_hold_ff();
        int n_ack = 0;
        tick(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 8'hFF, 1'b0);
            n_ack += int'(ACK_O);
            total++;
            if (ACK_O !== m_ack || o_led !== 1'b1 || o_busy !== 1'b1) begin
                bad++;
                $display("FAIL hold_ff i=%0d ack=%b/%b led=%b/1 busy=%b/1", i, ACK_O, m_ack, o_led, o_busy);
            end
        end
        total++;
        if (n_ack != 1) begin
            bad++;
            $display("FAIL hold_ff_ack_count got=%0d required=1", n_ack);
        end
        tick(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_abort();
        int n_ack = 0;
        tick(1'b1, 8'hF0, 1'b0);
        n_ack += int'(ACK_O);
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 8'h00, 1'b0);
            n_ack += int'(ACK_O);
        end
        for (int j = 0; j < 32; j++) begin
            tick((j == 0), 8'h0F, 1'b0);
            n_ack += int'(ACK_O);
            total++;
            if (o_led !== logic'(j >= 16) || ACK_O !== logic'(j == 0) || o_busy !== 1'b1) begin
                bad++;
                $display("FAIL abort j=%0d led=%b/%b ack=%b/%b busy=%b/1", j, o_led, logic'(j >= 16), ACK_O, logic'(j == 0), o_busy);
            end
        end
        total++;
        if (n_ack != 2) begin
            bad++;
            $display("FAIL abort_ack_count got=%0d required=2", n_ack);
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b0, 8'h00, 1'b0);
        tick(1'b1, 8'hAA, 1'b0);
        for (int i = 0; i < 7; i++) tick(1'b0, 8'h00, 1'b0);
        tick(1'b1, 8'h55, 1'b1);
        total++;
        if (ACK_O !== 1'b0 || o_led !== 1'b0 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid ack=%b led=%b busy=%b required 0 0 0", ACK_O, o_led, o_busy);
        end
        tick(1'b1, 8'h81, 1'b0);
        total++;
        if (ACK_O !== 1'b1 || o_led !== 1'b1 || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_release ack=%b led=%b busy=%b required 1 1 1", ACK_O, o_led, o_busy);
        end
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, 8'h00, 1'b0);
            total++;
            if (ACK_O !== m_ack || o_led !== m_led || o_busy !== m_busy) begin
                bad++;
                $display("FAIL reset_after i=%0d ack=%b/%b led=%b/%b busy=%b/%b", i, ACK_O, m_ack, o_led, m_led, o_busy, m_busy);
            end
        end
        tick(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_zero();
        tick(1'b1, 8'h00, 1'b0);
        total++;
        if (ACK_O !== 1'b1 || o_busy !== 1'b1 || o_led !== 1'b0) begin
            bad++;
            $display("FAIL zero_load ack=%b/1 busy=%b/1 led=%b/0", ACK_O, o_busy, o_led);
        end
        for (int i = 1; i < 64; i++) begin
            tick(1'b0, 8'hFF, 1'b0);
            total++;
            if (ACK_O !== 1'b0 || o_busy !== 1'b1 || o_led !== 1'b0) begin
                bad++;
                $display("FAIL zero_play i=%0d ack=%b/0 busy=%b/1 led=%b/0", i, ACK_O, o_busy, o_led);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        for (int i = 0; i < 12; i++) begin
            d = 8'($urandom);
            tick(logic'(i % 2 == 0), d, 1'b0);
            total++;
            if (ACK_O !== logic'(i % 2 == 0) || ACK_O !== m_ack || o_led !== m_led || o_busy !== m_busy) begin
                bad++;
                $display("FAIL back_to_back i=%0d ack=%b/%b led=%b/%b busy=%b/%b", i, ACK_O, m_ack, o_led, m_led, o_busy, m_busy);
            end
        end
    endtask

    task automatic test_random();
        logic stb;
        logic rst;
        for (int i = 0; i < 600; i++) begin
            stb = ($urandom_range(0, 9) == 0) ? ~STB_I : STB_I;
            rst = ($urandom_range(0, 79) == 0);
            tick(stb, 8'($urandom), rst);
            total++;
            if (ACK_O !== m_ack || o_led !== m_led || o_busy !== m_busy) begin
                bad++;
                $display("FAIL random i=%0d ack=%b/%b led=%b/%b busy=%b/%b", i, ACK_O, m_ack, o_led, m_led, o_busy, m_busy);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_a5();
        test_hold_ff();
        test_abort();
        test_reset_mid();
        test_zero();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
